multicycle_main_control: RTL and testbench
==========================================

Name: multicycle_main_control

Overview:
- Main control FSM for the multicycle MIPS datapath.
- Decodes the 6-bit opcode held in the instruction register and sequences one instruction over 3-5 steps.
- Drives every datapath enable and mux select, including ALUOp1/ALUOp2. The ALU control decoder consumes ALUOp1/ALUOp2 together with the funct field.
- Waits on a memory-ready handshake for every memory access.

Parameters:
- MEM_HANDSHAKE, 1, if 0 then MemReady is ignored and treated as constant 1 (single-cycle memory).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- Op  input  6  opcode, IR[31:26]; valid from DECODE onward.
- MemReady  input  1  memory has completed the current read/write this cycle.
- PCWrite  output  1  unconditional PC write.
- PCWriteCond  output  1  PC write if ALU Zero.
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  output  1  memory read request.
- MemWrite  output  1  memory write request.
- MemtoReg  output  1  write-back data select: 1 = MDR.
- IRWrite  output  1  instruction register load.
- PCSource  output  2  00 = ALU, 01 = ALUOut, 10 = jump target.
- ALUOp1  output  1  ALUOp MSB to ALU control.
- ALUOp2  output  1  ALUOp LSB to ALU control.
- ALUSrcB  output  2  00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- ALUSrcA  output  1  0 = PC, 1 = A.
- RegWrite  output  1  register file write.
- RegDst  output  1  destination register: 1 = rd, 0 = rt.
- IllegalOp  output  1  unsupported opcode seen in DECODE.
- State  output  4  current state, for debug.

Behaviour:
- Reset:
  - rst_n low forces State = IDLE (12) asynchronously.
  - All outputs are 0 in IDLE.
  - IDLE -> FETCH on the first clk edge after rst_n goes high.
  - Reset mid-instruction abandons it; no write strobe may be asserted while rst_n is low.
- State encoding: FETCH 0, DECODE 1, MEMADDR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTE 6, RWB 7, BRANCH 8, JUMP 9, ADDIEX 10, ADDIWB 11, IDLE 12. Codes 13-15 go to FETCH on the next edge with all outputs 0.
- Outputs are a combinational decode of State. Every output not listed for a state is 0.
  - FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite=PCWrite=MemReady (Mealy gating). Stay in FETCH while MemReady=0, go to DECODE when 1.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by Op:
    - 100011 (lw) or 101011 (sw) -> MEMADDR
    - 000000 (R-type) -> EXECUTE
    - 000100 (beq) -> BRANCH
    - 000010 (j) -> JUMP
    - 001000 (addi) -> ADDIEX
    - any other opcode -> FETCH with IllegalOp=1 for this single cycle.
  - MEMADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. lw -> MEMREAD, sw -> MEMWRITE.
  - MEMREAD: MemRead=1, IorD=1. Hold until MemReady, then -> MEMWB.
  - MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. -> FETCH.
  - MEMWRITE: MemWrite=1, IorD=1. Hold until MemReady, then -> FETCH.
  - EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10. -> RWB.
  - RWB: RegWrite=1, RegDst=1, MemtoReg=0. -> FETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. -> FETCH.
  - JUMP: PCWrite=1, PCSource=10. -> FETCH.
  - ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. -> ADDIWB.
  - ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0. -> FETCH.
- Mutual exclusion:
  - MemRead and MemWrite are never both 1.
  - PCWrite and PCWriteCond are never both 1.
  - Request outputs stay stable while waiting on MemReady.
- Op may change while in FETCH; it is only sampled in DECODE and MEMADDR.
- Cycle counts with MemReady tied high: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.

Test Plan:
- Reset held low 3 cycles, then released -> State 12 with all outputs 0 during reset; State 0 on the 1st edge after release; State 1 on the 2nd edge.
- Op=000000, MemReady=1 -> State sequence 0,1,6,7,0; {ALUOp1,ALUOp2}=10 in state 6; RegWrite=1 and RegDst=1 in state 7.
- Op=100011, MemReady low for 2 cycles in MEMREAD -> sequence 0,1,2,3,3,3,4,0; IorD=1 and MemRead=1 throughout state 3; MemtoReg=1 and RegWrite=1 in state 4.
- Op=000100 -> sequence 0,1,8,0; ALUOp=01, PCWriteCond=1, PCSource=01 in state 8.
- Op=111111 -> sequence 0,1,0; IllegalOp=1 only in state 1; RegWrite, MemWrite, PCWrite and PCWriteCond never asserted.
- MEM_HANDSHAKE=0 with MemReady=0, Op=101011 -> sequence 0,1,2,5,0 with no stall; rst_n pulsed low during state 5 -> MemWrite drops immediately and State=12.

Source files
------------

// File: rtl/multicycle_main_control.sv
// Main control FSM for the multicycle MIPS datapath: decodes the opcode and
// sequences one instruction over 3-5 steps, stalling on memory handshakes.
module multicycle_main_control #(
  parameter int MEM_HANDSHAKE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Op,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic [1:0] PCSource,
  output logic       ALUOp1,
  output logic       ALUOp2,
  output logic [1:0] ALUSrcB,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       IllegalOp,
  output logic [3:0] State
);

  // state    | meaning
  // FETCH    | read instruction at PC, PC <= PC + 4 when memory ready
  // DECODE   | read registers, precompute branch target, dispatch on Op
  // MEMADDR  | compute load/store effective address
  // MEMREAD  | load data memory access, wait for ready
  // MEMWB    | write loaded data to rt
  // MEMWRITE | store data memory access, wait for ready
  // EXECUTE  | R-type ALU operation
  // RWB      | write R-type result to rd
  // BRANCH   | beq compare, conditional PC write
  // JUMP     | PC <= jump target
  // ADDIEX   | addi ALU operation
  // ADDIWB   | write addi result to rt
  // IDLE     | held in / just leaving reset
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADDR  = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTE  = 4'd6,
    RWB      = 4'd7,
    BRANCH   = 4'd8,
    JUMP     = 4'd9,
    ADDIEX   = 4'd10,
    ADDIWB   = 4'd11,
    IDLE     = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  state_t state_q;
  state_t state_d;
  logic   mem_rdy;
  logic   op_illegal;

  // Without a handshake the memory is assumed to complete every access in one cycle.
  assign mem_rdy = (MEM_HANDSHAKE != 0) ? MemReady : 1'b1;

  always_comb begin
    op_illegal = 1'b0;
    case (Op)
      OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J, OP_ADDI: op_illegal = 1'b0;
      default:                                       op_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      IDLE:     state_d = FETCH;
      FETCH:    state_d = mem_rdy ? DECODE : FETCH;
      DECODE: begin
        case (Op)
          OP_LW, OP_SW: state_d = MEMADDR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
          OP_ADDI:      state_d = ADDIEX;
          default:      state_d = FETCH;
        endcase
      end
      MEMADDR:  state_d = (Op == OP_SW) ? MEMWRITE : MEMREAD;
      MEMREAD:  state_d = mem_rdy ? MEMWB : MEMREAD;
      MEMWB:    state_d = FETCH;
      MEMWRITE: state_d = mem_rdy ? FETCH : MEMWRITE;
      EXECUTE:  state_d = RWB;
      RWB:      state_d = FETCH;
      BRANCH:   state_d = FETCH;
      JUMP:     state_d = FETCH;
      ADDIEX:   state_d = ADDIWB;
      ADDIWB:   state_d = FETCH;
      default:  state_d = FETCH;
    endcase
  end

  // Outputs decode the current state only (FETCH write gating and IllegalOp
  // excepted), so the async reset to IDLE clears every strobe immediately.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    PCSource    = 2'b00;
    ALUOp1      = 1'b0;
    ALUOp2      = 1'b0;
    ALUSrcB     = 2'b00;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    IllegalOp   = 1'b0;
    case (state_q)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_rdy;
        PCWrite = mem_rdy;
      end
      DECODE: begin
        ALUSrcB   = 2'b11;
        IllegalOp = op_illegal;
      end
      MEMADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEMREAD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      MEMWRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUOp1  = 1'b1;
      end
      RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp2      = 1'b1;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      ADDIWB: begin
        RegWrite = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign State = state_q;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Directed bench for multicycle_main_control: walks each instruction class
// and compares State plus the packed control outputs against hand-built values.
module tb_multicycle_main_control;

  logic clk;
  logic rst_n, rst_n_b;
  logic [5:0] op, op_b;
  logic mem_ready, mem_ready_b;

  logic pc_write, pc_write_cond, iord, mem_read, mem_write, memto_reg, ir_write;
  logic [1:0] pc_source, alu_src_b;
  logic alu_op1, alu_op2, alu_src_a, reg_write, reg_dst, illegal_op;
  logic [3:0] state;

  logic pc_write_b, pc_write_cond_b, iord_b, mem_read_b, mem_write_b, memto_reg_b, ir_write_b;
  logic [1:0] pc_source_b, alu_src_b_b;
  logic alu_op1_b, alu_op2_b, alu_src_a_b, reg_write_b, reg_dst_b, illegal_op_b;
  logic [3:0] state_b;

  logic [16:0] outs, outs_b;
  int n_checks = 0;
  int n_errors = 0;

  // PCWrite PCWriteCond IorD MemRead MemWrite MemtoReg IRWrite PCSource ALUOp1 ALUOp2 ALUSrcB ALUSrcA RegWrite RegDst IllegalOp
  localparam logic [16:0] O_ZERO  = 17'b0;
  localparam logic [16:0] O_FETCH = 17'b1_0_0_1_0_0_1_00_0_0_01_0_0_0_0;
  localparam logic [16:0] O_FWAIT = 17'b0_0_0_1_0_0_0_00_0_0_01_0_0_0_0;
  localparam logic [16:0] O_DEC   = 17'b0_0_0_0_0_0_0_00_0_0_11_0_0_0_0;
  localparam logic [16:0] O_ILL   = 17'b0_0_0_0_0_0_0_00_0_0_11_0_0_0_1;
  localparam logic [16:0] O_MADDR = 17'b0_0_0_0_0_0_0_00_0_0_10_1_0_0_0;
  localparam logic [16:0] O_MRD   = 17'b0_0_1_1_0_0_0_00_0_0_00_0_0_0_0;
  localparam logic [16:0] O_MWB   = 17'b0_0_0_0_0_1_0_00_0_0_00_0_1_0_0;
  localparam logic [16:0] O_MWR   = 17'b0_0_1_0_1_0_0_00_0_0_00_0_0_0_0;
  localparam logic [16:0] O_EXE   = 17'b0_0_0_0_0_0_0_00_1_0_00_1_0_0_0;
  localparam logic [16:0] O_RWB   = 17'b0_0_0_0_0_0_0_00_0_0_00_0_1_1_0;
  localparam logic [16:0] O_BR    = 17'b0_1_0_0_0_0_0_01_0_1_00_1_0_0_0;
  localparam logic [16:0] O_JMP   = 17'b1_0_0_0_0_0_0_10_0_0_00_0_0_0_0;
  localparam logic [16:0] O_AWB   = 17'b0_0_0_0_0_0_0_00_0_0_00_0_1_0_0;

  multicycle_main_control dut (
    .clk(clk), .rst_n(rst_n), .Op(op), .MemReady(mem_ready),
    .PCWrite(pc_write), .PCWriteCond(pc_write_cond), .IorD(iord),
    .MemRead(mem_read), .MemWrite(mem_write), .MemtoReg(memto_reg),
    .IRWrite(ir_write), .PCSource(pc_source), .ALUOp1(alu_op1),
    .ALUOp2(alu_op2), .ALUSrcB(alu_src_b), .ALUSrcA(alu_src_a),
    .RegWrite(reg_write), .RegDst(reg_dst), .IllegalOp(illegal_op),
    .State(state)
  );

  multicycle_main_control #(.MEM_HANDSHAKE(0)) dut_nohs (
    .clk(clk), .rst_n(rst_n_b), .Op(op_b), .MemReady(mem_ready_b),
    .PCWrite(pc_write_b), .PCWriteCond(pc_write_cond_b), .IorD(iord_b),
    .MemRead(mem_read_b), .MemWrite(mem_write_b), .MemtoReg(memto_reg_b),
    .IRWrite(ir_write_b), .PCSource(pc_source_b), .ALUOp1(alu_op1_b),
    .ALUOp2(alu_op2_b), .ALUSrcB(alu_src_b_b), .ALUSrcA(alu_src_a_b),
    .RegWrite(reg_write_b), .RegDst(reg_dst_b), .IllegalOp(illegal_op_b),
    .State(state_b)
  );

  assign outs = {pc_write, pc_write_cond, iord, mem_read, mem_write, memto_reg, ir_write,
                 pc_source, alu_op1, alu_op2, alu_src_b, alu_src_a, reg_write, reg_dst, illegal_op};
  assign outs_b = {pc_write_b, pc_write_cond_b, iord_b, mem_read_b, mem_write_b, memto_reg_b, ir_write_b,
                   pc_source_b, alu_op1_b, alu_op2_b, alu_src_b_b, alu_src_a_b, reg_write_b, reg_dst_b, illegal_op_b};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [16:0] got, input logic [16:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_a(input string tag, input logic [3:0] st, input logic [16:0] ov);
    chk({tag, " state"}, {13'b0, state}, {13'b0, st});
    chk({tag, " outs"}, outs, ov);
  endtask

  task automatic expect_b(input string tag, input logic [3:0] st, input logic [16:0] ov);
    chk({tag, " state"}, {13'b0, state_b}, {13'b0, st});
    chk({tag, " outs"}, outs_b, ov);
  endtask

  initial begin
    rst_n = 1'b1; rst_n_b = 1'b1;
    op = 6'b0; op_b = 6'b101011;
    mem_ready = 1'b1; mem_ready_b = 1'b0;
    #2;
    rst_n = 1'b0; rst_n_b = 1'b0;

    for (int i = 0; i < 3; i++) begin
      step();
      expect_a("reset", 4'd12, O_ZERO);
    end
    expect_b("reset_nohs", 4'd12, O_ZERO);
    rst_n = 1'b1;

    // R-type
    step(); expect_a("rt_fetch", 4'd0, O_FETCH);
    step(); expect_a("rt_decode", 4'd1, O_DEC);
    step(); expect_a("rt_exec", 4'd6, O_EXE);
    step(); expect_a("rt_wb", 4'd7, O_RWB);
    step(); expect_a("rt_done", 4'd0, O_FETCH);

    // FETCH stall with Op changing, then lw with MEMREAD stall
    mem_ready = 1'b0; #1;
    expect_a("fetch_wait", 4'd0, O_FWAIT);
    op = 6'b100011;
    step(); expect_a("fetch_hold", 4'd0, O_FWAIT);
    mem_ready = 1'b1; #1;
    expect_a("fetch_go", 4'd0, O_FETCH);
    step(); expect_a("lw_decode", 4'd1, O_DEC);
    step(); expect_a("lw_addr", 4'd2, O_MADDR);
    step(); expect_a("lw_read", 4'd3, O_MRD);
    mem_ready = 1'b0;
    step(); expect_a("lw_stall1", 4'd3, O_MRD);
    step(); expect_a("lw_stall2", 4'd3, O_MRD);
    mem_ready = 1'b1;
    step(); expect_a("lw_wb", 4'd4, O_MWB);
    step(); expect_a("lw_done", 4'd0, O_FETCH);

    // beq
    op = 6'b000100;
    step(); expect_a("beq_decode", 4'd1, O_DEC);
    step(); expect_a("beq_branch", 4'd8, O_BR);
    step(); expect_a("beq_done", 4'd0, O_FETCH);

    // illegal opcode
    op = 6'b111111;
    step(); expect_a("ill_decode", 4'd1, O_ILL);
    step(); expect_a("ill_done", 4'd0, O_FETCH);

    // j
    op = 6'b000010;
    step(); expect_a("j_decode", 4'd1, O_DEC);
    step(); expect_a("j_jump", 4'd9, O_JMP);
    step(); expect_a("j_done", 4'd0, O_FETCH);

    // addi
    op = 6'b001000;
    step(); expect_a("addi_decode", 4'd1, O_DEC);
    step(); expect_a("addi_exec", 4'd10, O_MADDR);
    step(); expect_a("addi_wb", 4'd11, O_AWB);
    step(); expect_a("addi_done", 4'd0, O_FETCH);

    // sw with one stall cycle
    op = 6'b101011;
    step(); expect_a("sw_decode", 4'd1, O_DEC);
    step(); expect_a("sw_addr", 4'd2, O_MADDR);
    step(); expect_a("sw_write", 4'd5, O_MWR);
    mem_ready = 1'b0;
    step(); expect_a("sw_stall", 4'd5, O_MWR);
    mem_ready = 1'b1;
    step(); expect_a("sw_done", 4'd0, O_FETCH);

    // No-handshake instance: MemReady held low is ignored
    rst_n_b = 1'b1;
    step(); expect_b("nh_fetch", 4'd0, O_FETCH);
    step(); expect_b("nh_decode", 4'd1, O_DEC);
    step(); expect_b("nh_addr", 4'd2, O_MADDR);
    step(); expect_b("nh_write", 4'd5, O_MWR);
    step(); expect_b("nh_done", 4'd0, O_FETCH);
    step(); expect_b("nh_decode2", 4'd1, O_DEC);
    step(); expect_b("nh_addr2", 4'd2, O_MADDR);
    step(); expect_b("nh_write2", 4'd5, O_MWR);
    rst_n_b = 1'b0; #1;
    chk("nh_rst_memwrite", {16'b0, mem_write_b}, 17'b0);
    expect_b("nh_rst_async", 4'd12, O_ZERO);
    step(); expect_b("nh_rst_hold", 4'd12, O_ZERO);
    rst_n_b = 1'b1;
    step(); expect_b("nh_restart", 4'd0, O_FETCH);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
